// File: rtl/music_pkg.sv
// Shared note-code layout, letter codes and the octave-0 half-period table.
// BASE values are derived from the clock frequency at elaboration time.
package music_pkg;

    localparam int NOTE_W    = 9;
    localparam int SHARP_BIT = 8;
    localparam int LET_HI    = 7;
    localparam int LET_LO    = 4;
    localparam int OCT_HI    = 3;
    localparam int OCT_LO    = 0;
    localparam int OCT_MAX   = 8;
    localparam int BASE_W    = 21;

    localparam logic [NOTE_W-1:0] REST_CODE = 9'h111;

    localparam logic [3:0] LET_G = 4'h0;
    localparam logic [3:0] LET_A = 4'hA;
    localparam logic [3:0] LET_B = 4'hB;
    localparam logic [3:0] LET_C = 4'hC;
    localparam logic [3:0] LET_D = 4'hD;
    localparam logic [3:0] LET_E = 4'hE;
    localparam logic [3:0] LET_F = 4'hF;

    localparam logic [3:0] SEMI_C = 4'd0;
    localparam logic [3:0] SEMI_D = 4'd2;
    localparam logic [3:0] SEMI_E = 4'd4;
    localparam logic [3:0] SEMI_F = 4'd5;
    localparam logic [3:0] SEMI_G = 4'd7;
    localparam logic [3:0] SEMI_A = 4'd9;
    localparam logic [3:0] SEMI_B = 4'd11;

    // Octave-0 pitches in micro-hertz, rounded half-period in clocks.
    function automatic logic [BASE_W-1:0] base_half(
        input longint clk_hz,
        input int     semi
    );
        longint f;
        case (semi)
            0:       f = 64'd16351598;
            1:       f = 64'd17323914;
            2:       f = 64'd18354048;
            3:       f = 64'd19445436;
            4:       f = 64'd20601722;
            5:       f = 64'd21826764;
            6:       f = 64'd23124651;
            7:       f = 64'd24499715;
            8:       f = 64'd25956544;
            9:       f = 64'd27500000;
            10:      f = 64'd29135235;
            default: f = 64'd30867706;
        endcase
        return BASE_W'((clk_hz * 64'd1000000 + f) / (2 * f));
    endfunction

endpackage

// File: rtl/note_decoder.sv
// Combinational note-code decode to rest flag and half-period in clocks.
// Sharps past B wrap to C of the next octave; H never decodes to zero.
module note_decoder
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic [NOTE_W-1:0] code,
    output logic              rest,
    output logic [BASE_W-1:0] half
);

    localparam logic [BASE_W-1:0] BASE [12] = '{
        base_half(CLK_HZ, 0),  base_half(CLK_HZ, 1),
        base_half(CLK_HZ, 2),  base_half(CLK_HZ, 3),
        base_half(CLK_HZ, 4),  base_half(CLK_HZ, 5),
        base_half(CLK_HZ, 6),  base_half(CLK_HZ, 7),
        base_half(CLK_HZ, 8),  base_half(CLK_HZ, 9),
        base_half(CLK_HZ, 10), base_half(CLK_HZ, 11)
    };

    logic [3:0]        letter;
    logic [4:0]        oct;
    logic [3:0]        semi;
    logic              bad;
    logic [BASE_W-1:0] shifted;

    always_comb begin
        letter  = code[LET_HI:LET_LO];
        oct     = {1'b0, code[OCT_HI:OCT_LO]};
        semi    = 4'd0;
        bad     = 1'b0;
        shifted = '0;
        case (letter)
            LET_C:   semi = SEMI_C;
            LET_D:   semi = SEMI_D;
            LET_E:   semi = SEMI_E;
            LET_F:   semi = SEMI_F;
            LET_G:   semi = SEMI_G;
            LET_A:   semi = SEMI_A;
            LET_B:   semi = SEMI_B;
            default: bad  = 1'b1;
        endcase
        semi = semi + {3'b000, code[SHARP_BIT]};
        if (semi == 4'd12) begin
            semi = 4'd0;
            oct  = oct + 5'd1;
        end
        rest    = bad || (oct > 5'(OCT_MAX));
        shifted = BASE[semi] >> oct;
        if (rest || shifted == '0) begin
            half = BASE_W'(1);
        end else begin
            half = shifted;
        end
    end

endmodule

// File: rtl/eight_bit_music.sv
// Square-wave tone generator: latches a note code on each load strobe.
// Define NOTE_GAP_EN to insert GAP_CYCLES of silence after every load.
module eight_bit_music
    import music_pkg::*;
#(
`ifdef NOTE_GAP_EN
    parameter int unsigned GAP_CYCLES = 500_000,
`endif
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_NextNote,
    input  logic [NOTE_W-1:0] i_Note,
    output logic              o_Frequency
);

    logic [NOTE_W-1:0] note;
    logic [BASE_W-1:0] cnt;
    logic [BASE_W-1:0] half;
    logic              rest;
    logic              hold;

    note_decoder #(
        .CLK_HZ(CLK_HZ)
    ) u_dec (
        .code(note),
        .rest(rest),
        .half(half)
    );

`ifdef NOTE_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [GAP_W-1:0] gap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap <= '0;
        end else if (i_NextNote) begin
            gap <= GAP_W'(GAP_CYCLES);
        end else if (gap != '0) begin
            gap <= gap - 1'b1;
        end
    end

    assign hold = (gap != '0);
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            note        <= REST_CODE;
            cnt         <= '0;
            o_Frequency <= 1'b0;
        end else if (i_NextNote) begin
            note        <= i_Note;
            cnt         <= '0;
            o_Frequency <= 1'b0;
        end else if (rest || hold) begin
            cnt         <= '0;
            o_Frequency <= 1'b0;
        end else if (cnt >= half - 1'b1) begin
            cnt         <= '0;
            o_Frequency <= ~o_Frequency;
        end else begin
            cnt         <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_eight_bit_music.sv
// Scoreboard bench: expected output edges are queued by the stimulus and
// consumed by a monitor; clock scaled to 5 MHz so H = BASE/10 values.
module tb_eight_bit_music;

`ifdef NOTE_GAP_EN
    localparam int G = 500;
`else
    localparam int G = 0;
`endif

    // Half-periods at CLK_HZ = 5 MHz, hand-derived from round(CLK/(2*f0)) >> oct.
    localparam int H_A4 = 5681;
    localparam int H_E7 = 948;
    localparam int H_AS6 = 1340;
    localparam int H_C8 = 597;
    localparam int H_A7 = 710;

    typedef struct {
        int   cyc;
        logic lvl;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nn;
    logic [8:0] note;
    logic       freq;

    ev_t q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  ncmp = 0;
    int  nfail = 0;
    int  lcyc = 0;
    logic prev = 1'b0;
    bit   mon_on = 1'b0;

    always #5 clk = ~clk;

`ifdef NOTE_GAP_EN
    eight_bit_music #(
        .GAP_CYCLES(G),
        .CLK_HZ(5_000_000)
    ) dut (
`else
    eight_bit_music #(
        .CLK_HZ(5_000_000)
    ) dut (
`endif
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_NextNote(nn),
        .i_Note(note),
        .o_Frequency(freq)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on && freq !== prev) begin
            ncmp++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_edge cyc=%0d level got %b want none",
                         cyc, freq);
            end else begin
                mon_e = q.pop_front();
                if ((mon_e.cyc >= 0 && mon_e.cyc != cyc) || freq !== mon_e.lvl) begin
                    nfail++;
                    $display("FAIL edge got cyc=%0d lvl=%b want cyc=%0d lvl=%b",
                             cyc, freq, mon_e.cyc, mon_e.lvl);
                end
            end
        end
        if (mon_on) prev = freq;
    end

    task automatic chk(input string nm, input logic got, input logic exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got %b want %b", nm, got, exp);
        end
    endtask

    task automatic push(input int c, input logic l);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        q.push_back(e);
    endtask

    task automatic tone(input int h, input int n);
        for (int k = 1; k <= n; k++) begin
            push(lcyc + G + k * h, k[0]);
        end
    endtask

    task automatic load(input logic [8:0] c);
        @(negedge clk);
        note = c;
        nn   = 1'b1;
        @(posedge clk);
        #1;
        lcyc = cyc;
        nn   = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        ncmp++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL %s timeout pending got %0d want 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        nn    = 1'b0;
        note  = 9'h000;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_out", freq, 1'b0);
        rst_n  = 1'b1;
        prev   = freq;
        mon_on = 1'b1;

        idle(10000);
        chk("idle_after_reset", freq, 1'b0);

        load(9'h0A4);
        tone(H_A4, 4);
        drain("a4", G + 4 * H_A4 + 100);
        chk("a4_end_low", freq, 1'b0);
        idle(100);

        load(9'h0E7);
        tone(H_E7, 3);
        drain("e7", G + 3 * H_E7 + 100);
        chk("e7_high", freq, 1'b1);
        idle(10);
        load(9'h1A6);
        push(lcyc, 1'b0);
        tone(H_AS6, 2);
        drain("as6_restart", G + 2 * H_AS6 + 100);

        load(9'h1B7);
        tone(H_C8, 3);
        drain("bs7_as_c8", G + 3 * H_C8 + 100);
        chk("c8_high", freq, 1'b1);
        load(9'h111);
        push(lcyc, 1'b0);
        idle(1500);
        drain("rest_111", 10);
        chk("rest_111_low", freq, 1'b0);

        load(9'h095);
        idle(1500);
        chk("rest_letter9", freq, 1'b0);
        load(9'h0A9);
        idle(1500);
        chk("rest_oct9", freq, 1'b0);

        @(negedge clk);
        note = 9'h0A4;
        nn   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        lcyc = cyc;
        nn   = 1'b0;
        tone(H_A4, 1);
        drain("strobe_held", G + H_A4 + 100);
        chk("a4_high_before_rst", freq, 1'b1);

        idle(100);
        @(posedge clk);
        #3;
        push(-1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", freq, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1500);
        drain("reset_edge", 10);
        chk("rest_after_reset", freq, 1'b0);

        load(9'h0A7);
        tone(H_A7, 2);
        drain("a7", G + 2 * H_A7 + 100);
        chk("a7_end_low", freq, 1'b0);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
